// File: rtl/ex_ctrl_pkg.sv
// Shared types and encodings for the execute-stage sequencer: FSM states,
// ALUctrl codes, forwarding-select codes and the ID/EX control bundle.
package ex_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] ALU_BEQ = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       branch;
    logic       mem_read;
    logic       reg_write;
  } ex_ctrl_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ex_fwd_unit.sv
// Operand-forwarding compare for both ALU operands. EX/MEM results are newer
// than MEM/WB results, so they win when both stages target the same register.
module ex_fwd_unit
  import ex_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  function automatic logic [1:0] pick(
    input logic [RA_W-1:0] src,
    input logic            m_we,
    input logic [RA_W-1:0] m_rd,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    // Register 0 is hardwired, so a write to it never produces a forwardable value.
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      sel = FWD_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_valid) begin
      fwd_a = pick(ex_rs, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      fwd_b = pick(ex_rt, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencer: owns the ID/EX control register, stalls on load-use
// hazards, flushes on taken branches and drives the forwarding selects.
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int RA_W      = 5,
  parameter int FLUSH_CYC = 1,
  parameter int LU_STALL  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_dst,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_reg_write,
  input  logic [1:0]      id_alu_ctrl,
  input  logic            alu_branch,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output logic            ex_valid,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_dst,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_reg_write,
  output logic [1:0]      ex_alu_ctrl,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            branch_taken,
  output logic [1:0]      dbg_state
);

  localparam int CNT_MAX = max2(FLUSH_CYC, LU_STALL);
  localparam int CW      = $clog2(CNT_MAX) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ex_valid_q, ex_valid_d;
  logic [RA_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  ex_ctrl_t        ctrl_q, ctrl_d;
  logic            taken, lu_haz, bubble;

  // ALUctrl 11 passes through but is never a branch compare.
  assign taken  = ex_valid_q & ctrl_q.branch & (ctrl_q.alu_ctrl == ALU_BEQ) & alu_branch;
  assign lu_haz = ex_valid_q & ctrl_q.mem_read & id_valid & (ex_rt_q != '0) &
                  ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    branch_taken = 1'b0;
    bubble       = 1'b0;
    unique case (state_q)
      RUN: begin
        // A taken branch wins: the instruction a stall would hold is wrong-path.
        if (taken) begin
          branch_taken = 1'b1;
          ifid_flush   = 1'b1;
          bubble       = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYC - 1);
          end
        end else if (lu_haz) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          if (LU_STALL > 1) begin
            state_d = STALL;
            cnt_d   = CW'(LU_STALL - 1);
          end
        end
      end
      STALL: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b1;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        bubble     = 1'b1;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A bubble clears validity and every control bit; addresses load regardless.
  always_comb begin
    ex_rs_d    = id_rs;
    ex_rt_d    = id_rt;
    ex_rd_d    = id_rd;
    ex_valid_d = bubble ? 1'b0 : id_valid;
    ctrl_d     = '0;
    if (!bubble) begin
      ctrl_d = '{reg_dst: id_reg_dst, alu_src: id_alu_src, alu_ctrl: id_alu_ctrl,
                 branch: id_branch, mem_read: id_mem_read, reg_write: id_reg_write};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_dst   = ctrl_q.reg_dst;
  assign ex_alu_src   = ctrl_q.alu_src;
  assign ex_alu_ctrl  = ctrl_q.alu_ctrl;
  assign ex_branch    = ctrl_q.branch;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_reg_write = ctrl_q.reg_write;
  assign dbg_state    = state_q;

  ex_fwd_unit #(.RA_W(RA_W)) u_fwd (
    .ex_valid      (ex_valid_q),
    .ex_rs         (ex_rs_q),
    .ex_rt         (ex_rt_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: two instances (FLUSH_CYC/LU_STALL = 1/1 and 2/2)
// share one stimulus stream and are compared against a penalty-counting model.
module tb_ex_hazard_ctrl;
  import ex_ctrl_pkg::*;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       reg_dst, alu_src;
    logic [1:0] alu_ctrl;
    logic       branch, mem_read, reg_write;
    logic       alu_branch;
    logic       mem_reg_write;
    logic [4:0] mem_rd;
    logic       wb_reg_write;
    logic [4:0] wb_rd;
  } in_t;

  typedef struct packed {
    logic       ex_valid;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       reg_dst, alu_src;
    logic [1:0] alu_ctrl;
    logic       branch, mem_read, reg_write;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_write, ifid_write, ifid_flush, branch_taken;
    logic [1:0] st;
  } out_t;

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt, rd;
    logic       reg_dst, alu_src;
    logic [1:0] alu_ctrl;
    logic       branch, mem_read, reg_write;
    int         flush_left;
    int         stall_left;
  } model_t;

  typedef struct {
    in_t        in;
    logic       exv, pc, ifw, fl, bt;
    logic [1:0] fa, fb, st;
  } vec_t;

  localparam int K_NOP = 0, K_LW = 1, K_ADD = 2, K_BEQ = 3, K_LWBR = 4, K_BR11 = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  in_t    cur;
  model_t ma, mb;
  int     n_tests = 0;
  int     n_fail  = 0;

  logic       a_ex_valid, a_ex_reg_dst, a_ex_alu_src, a_ex_branch, a_ex_mem_read, a_ex_reg_write;
  logic [4:0] a_ex_rs, a_ex_rt, a_ex_rd;
  logic [1:0] a_ex_alu_ctrl, a_fwd_a, a_fwd_b, a_dbg_state;
  logic       a_pc_write, a_ifid_write, a_ifid_flush, a_branch_taken;
  logic       b_ex_valid, b_ex_reg_dst, b_ex_alu_src, b_ex_branch, b_ex_mem_read, b_ex_reg_write;
  logic [4:0] b_ex_rs, b_ex_rt, b_ex_rd;
  logic [1:0] b_ex_alu_ctrl, b_fwd_a, b_fwd_b, b_dbg_state;
  logic       b_pc_write, b_ifid_write, b_ifid_flush, b_branch_taken;
  out_t       oa, ob;

  assign oa = {a_ex_valid, a_ex_rs, a_ex_rt, a_ex_rd, a_ex_reg_dst, a_ex_alu_src, a_ex_alu_ctrl,
               a_ex_branch, a_ex_mem_read, a_ex_reg_write, a_fwd_a, a_fwd_b, a_pc_write,
               a_ifid_write, a_ifid_flush, a_branch_taken, a_dbg_state};
  assign ob = {b_ex_valid, b_ex_rs, b_ex_rt, b_ex_rd, b_ex_reg_dst, b_ex_alu_src, b_ex_alu_ctrl,
               b_ex_branch, b_ex_mem_read, b_ex_reg_write, b_fwd_a, b_fwd_b, b_pc_write,
               b_ifid_write, b_ifid_flush, b_branch_taken, b_dbg_state};

  ex_hazard_ctrl #(.RA_W(5), .FLUSH_CYC(1), .LU_STALL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(cur.id_valid), .id_rs(cur.id_rs), .id_rt(cur.id_rt),
    .id_rd(cur.id_rd), .id_reg_dst(cur.reg_dst), .id_alu_src(cur.alu_src), .id_branch(cur.branch),
    .id_mem_read(cur.mem_read), .id_reg_write(cur.reg_write), .id_alu_ctrl(cur.alu_ctrl),
    .alu_branch(cur.alu_branch), .mem_reg_write(cur.mem_reg_write), .mem_rd(cur.mem_rd),
    .wb_reg_write(cur.wb_reg_write), .wb_rd(cur.wb_rd),
    .ex_valid(a_ex_valid), .ex_rs(a_ex_rs), .ex_rt(a_ex_rt), .ex_rd(a_ex_rd),
    .ex_reg_dst(a_ex_reg_dst), .ex_alu_src(a_ex_alu_src), .ex_branch(a_ex_branch),
    .ex_mem_read(a_ex_mem_read), .ex_reg_write(a_ex_reg_write), .ex_alu_ctrl(a_ex_alu_ctrl),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
    .ifid_flush(a_ifid_flush), .branch_taken(a_branch_taken), .dbg_state(a_dbg_state)
  );

  ex_hazard_ctrl #(.RA_W(5), .FLUSH_CYC(2), .LU_STALL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(cur.id_valid), .id_rs(cur.id_rs), .id_rt(cur.id_rt),
    .id_rd(cur.id_rd), .id_reg_dst(cur.reg_dst), .id_alu_src(cur.alu_src), .id_branch(cur.branch),
    .id_mem_read(cur.mem_read), .id_reg_write(cur.reg_write), .id_alu_ctrl(cur.alu_ctrl),
    .alu_branch(cur.alu_branch), .mem_reg_write(cur.mem_reg_write), .mem_rd(cur.mem_rd),
    .wb_reg_write(cur.wb_reg_write), .wb_rd(cur.wb_rd),
    .ex_valid(b_ex_valid), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt), .ex_rd(b_ex_rd),
    .ex_reg_dst(b_ex_reg_dst), .ex_alu_src(b_ex_alu_src), .ex_branch(b_ex_branch),
    .ex_mem_read(b_ex_mem_read), .ex_reg_write(b_ex_reg_write), .ex_alu_ctrl(b_ex_alu_ctrl),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
    .ifid_flush(b_ifid_flush), .branch_taken(b_branch_taken), .dbg_state(b_dbg_state)
  );

  // reference model: tracks the ID/EX contents plus remaining penalty cycles
  function automatic model_t model_rst();
    model_t m;
    m.valid = 1'b0; m.rs = '0; m.rt = '0; m.rd = '0;
    m.reg_dst = 1'b0; m.alu_src = 1'b0; m.alu_ctrl = 2'b00;
    m.branch = 1'b0; m.mem_read = 1'b0; m.reg_write = 1'b0;
    m.flush_left = 0; m.stall_left = 0;
    return m;
  endfunction

  function automatic logic is_taken(model_t m, in_t i);
    return m.valid && m.branch && (m.alu_ctrl == 2'b00) && i.alu_branch;
  endfunction

  function automatic logic is_lu(model_t m, in_t i);
    return m.valid && m.mem_read && i.id_valid && (m.rt != 0) && (m.rt == i.id_rs || m.rt == i.id_rt);
  endfunction

  function automatic logic [1:0] fwd_ref(logic v, logic [4:0] src, in_t i);
    if (!v) return FWD_RF;
    if (i.mem_reg_write && i.mem_rd != 0 && i.mem_rd == src) return FWD_MEM;
    if (i.wb_reg_write && i.wb_rd != 0 && i.wb_rd == src) return FWD_WB;
    return FWD_RF;
  endfunction

  function automatic out_t model_out(model_t m, in_t i);
    out_t o;
    o = '0;
    o.ex_valid = m.valid; o.ex_rs = m.rs; o.ex_rt = m.rt; o.ex_rd = m.rd;
    o.reg_dst = m.reg_dst; o.alu_src = m.alu_src; o.alu_ctrl = m.alu_ctrl;
    o.branch = m.branch; o.mem_read = m.mem_read; o.reg_write = m.reg_write;
    o.fwd_a = fwd_ref(m.valid, m.rs, i);
    o.fwd_b = fwd_ref(m.valid, m.rt, i);
    o.pc_write = 1'b1; o.ifid_write = 1'b1;
    o.st = RUN;
    if (m.flush_left > 0) begin
      o.ifid_flush = 1'b1; o.st = FLUSH;
    end else if (m.stall_left > 0) begin
      o.pc_write = 1'b0; o.ifid_write = 1'b0; o.st = STALL;
    end else if (is_taken(m, i)) begin
      o.branch_taken = 1'b1; o.ifid_flush = 1'b1;
    end else if (is_lu(m, i)) begin
      o.pc_write = 1'b0; o.ifid_write = 1'b0;
    end
    return o;
  endfunction

  function automatic model_t model_next(model_t m, in_t i, int fc, int ls);
    model_t n;
    logic bub;
    n = m;
    n.flush_left = 0;
    n.stall_left = 0;
    bub = 1'b1;
    if (m.flush_left > 0)       n.flush_left = m.flush_left - 1;
    else if (m.stall_left > 0)  n.stall_left = m.stall_left - 1;
    else if (is_taken(m, i))    n.flush_left = fc - 1;
    else if (is_lu(m, i))       n.stall_left = ls - 1;
    else                        bub = 1'b0;
    n.rs = i.id_rs; n.rt = i.id_rt; n.rd = i.id_rd;
    n.valid     = bub ? 1'b0 : i.id_valid;
    n.reg_dst   = bub ? 1'b0 : i.reg_dst;
    n.alu_src   = bub ? 1'b0 : i.alu_src;
    n.alu_ctrl  = bub ? 2'b00 : i.alu_ctrl;
    n.branch    = bub ? 1'b0 : i.branch;
    n.mem_read  = bub ? 1'b0 : i.mem_read;
    n.reg_write = bub ? 1'b0 : i.reg_write;
    return n;
  endfunction

  // stimulus builders
  function automatic in_t mk(int kind, int rs, int rt, int rd, int ab, int mw, int mrd, int ww, int wrd);
    in_t v;
    v = '0;
    v.id_valid = (kind != K_NOP);
    v.id_rs = 5'(rs); v.id_rt = 5'(rt); v.id_rd = 5'(rd);
    case (kind)
      K_LW:   begin v.mem_read = 1'b1; v.reg_write = 1'b1; v.alu_src = 1'b1; v.alu_ctrl = ALU_ADD; end
      K_ADD:  begin v.reg_dst = 1'b1; v.reg_write = 1'b1; v.alu_ctrl = ALU_ADD; end
      K_BEQ:  begin v.branch = 1'b1; v.alu_ctrl = ALU_BEQ; end
      K_LWBR: begin v.branch = 1'b1; v.mem_read = 1'b1; v.reg_write = 1'b1; v.alu_src = 1'b1;
                    v.alu_ctrl = ALU_BEQ; end
      K_BR11: begin v.branch = 1'b1; v.alu_ctrl = 2'b11; end
      default: v.alu_ctrl = ALU_SUB;
    endcase
    v.alu_branch = ab[0];
    v.mem_reg_write = mw[0]; v.mem_rd = 5'(mrd);
    v.wb_reg_write = ww[0];  v.wb_rd = 5'(wrd);
    return v;
  endfunction

  function automatic vec_t vec(in_t i, int exv, int pc, int ifw, int fl, int bt, int fa, int fb, int st);
    vec_t r;
    r.in = i; r.exv = exv[0]; r.pc = pc[0]; r.ifw = ifw[0]; r.fl = fl[0]; r.bt = bt[0];
    r.fa = 2'(fa); r.fb = 2'(fb); r.st = 2'(st);
    return r;
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_models(input string tag);
    chk({tag, "_a"}, 64'(oa), 64'(model_out(ma, cur)));
    chk({tag, "_b"}, 64'(ob), 64'(model_out(mb, cur)));
  endtask

  // driver: apply one cycle of inputs, check mid-cycle, advance models at the edge
  task automatic step(input in_t v, input string tag);
    cur = v;
    #2;
    chk_models(tag);
    @(posedge clk);
    ma = model_next(ma, v, 1, 1);
    mb = model_next(mb, v, 2, 2);
    #1;
  endtask

  task automatic do_reset();
    chk_models("pre_rst");
    rst_n = 1'b0;
    #1;
    ma = model_rst();
    mb = model_rst();
    chk_models("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = vec(mk(K_LW,   1, 5, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = vec(mk(K_ADD,  5, 2, 3, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = vec(mk(K_ADD,  5, 2, 3, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = vec(mk(K_ADD,  5, 2, 3, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = vec(mk(K_NOP,  0, 0, 0, 0, 1, 5, 1, 5), 1, 1, 1, 0, 0, 2, 0, 0);
    tbl[5]  = vec(mk(K_LW,   0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = vec(mk(K_ADD,  0, 0, 1, 0, 1, 0, 0, 0), 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[7]  = vec(mk(K_BEQ,  1, 2, 0, 0, 0, 0, 0, 0), 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[8]  = vec(mk(K_ADD,  9, 9, 9, 1, 0, 0, 0, 0), 1, 1, 1, 1, 1, 0, 0, 0);
    tbl[9]  = vec(mk(K_ADD,  9, 9, 9, 1, 0, 0, 0, 0), 0, 1, 1, 1, 0, 0, 0, 2);
    tbl[10] = vec(mk(K_LWBR, 1, 4, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[11] = vec(mk(K_ADD,  4, 0, 6, 1, 0, 0, 0, 0), 1, 1, 1, 1, 1, 0, 0, 0);
    tbl[12] = vec(mk(K_ADD,  4, 0, 6, 1, 0, 0, 0, 0), 0, 1, 1, 1, 0, 0, 0, 2);
    tbl[13] = vec(mk(K_BR11, 1, 2, 0, 1, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[14] = vec(mk(K_NOP,  0, 0, 0, 1, 0, 1, 1, 1), 1, 1, 1, 0, 0, 1, 0, 0);

    cur = '0;
    ma = model_rst();
    mb = model_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc_write", 64'(b_pc_write), 64'(1));
    chk("reset_ex_valid", 64'(b_ex_valid), 64'(0));
    chk("reset_state", 64'(b_dbg_state), 64'(RUN));
    rst_n = 1'b1;
    chk_models("reset");

    // reset while dut_b is part-way through a two-cycle stall
    step(mk(K_LW,  1, 5, 0, 0, 0, 0, 0, 0), "t1_lw");
    step(mk(K_ADD, 5, 0, 2, 0, 1, 5, 0, 0), "t1_use");
    chk("t1_in_stall", 64'(b_dbg_state), 64'(STALL));
    rst_n = 1'b0;
    #1;
    ma = model_rst();
    mb = model_rst();
    chk("t1_pc_write", 64'(b_pc_write), 64'(1));
    chk("t1_ex_valid", 64'(b_ex_valid), 64'(0));
    chk("t1_fwd", 64'({b_fwd_a, b_fwd_b}), 64'(0));
    chk("t1_state", 64'(b_dbg_state), 64'(RUN));
    chk_models("t1_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed table, expectations for the FLUSH_CYC=2 / LU_STALL=2 instance
    for (int k = 0; k < 15; k++) begin
      cur = tbl[k].in;
      #2;
      chk($sformatf("tbl%0d_exv", k), 64'(b_ex_valid), 64'(tbl[k].exv));
      chk($sformatf("tbl%0d_pc", k), 64'({b_pc_write, b_ifid_write}), 64'({tbl[k].pc, tbl[k].ifw}));
      chk($sformatf("tbl%0d_flush", k), 64'({b_ifid_flush, b_branch_taken}), 64'({tbl[k].fl, tbl[k].bt}));
      chk($sformatf("tbl%0d_fwd", k), 64'({b_fwd_a, b_fwd_b}), 64'({tbl[k].fa, tbl[k].fb}));
      chk($sformatf("tbl%0d_state", k), 64'(b_dbg_state), 64'(tbl[k].st));
      chk_models($sformatf("tbl%0d", k));
      @(posedge clk);
      ma = model_next(ma, tbl[k].in, 1, 1);
      mb = model_next(mb, tbl[k].in, 2, 2);
      #1;
    end

    // randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      in_t v;
      if ($urandom_range(0, 199) == 0) do_reset();
      v = mk(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) v.alu_ctrl = 2'($urandom_range(0, 3));
      step(v, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
